// File: rtl/bank_swap_scheduler.sv
// Ping-pong double buffer controller over two external single-port banks.
// Optional frame repeat of the read bank: define BANK_SWAP_REPEAT_EN.
module bank_swap_scheduler #(
  parameter int DW = 8,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          wr_valid,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ready,
  input  logic          rd_en,
  output logic          rd_avail,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic          ram1_write_en,
  output logic          ram2_write_en,
  output logic [AW-1:0] ram1_write_address,
  output logic [AW-1:0] ram2_write_address,
  output logic [AW-1:0] ram1_read_address,
  output logic [AW-1:0] ram2_read_address,
  output logic [DW-1:0] ram1_write_data,
  output logic [DW-1:0] ram2_write_data,
  output logic          ram1_read_en,
  output logic          ram2_read_en,
  input  logic [DW-1:0] ram1_read_data,
  input  logic [DW-1:0] ram2_read_data,
  output logic          wr_bank,
  output logic          swap
);

`ifdef BANK_SWAP_REPEAT_EN
  localparam bit REPEAT = 1'b1;
`else
  localparam bit REPEAT = 1'b0;
`endif

  localparam logic [AW-1:0] ONE = {{(AW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    FILL0, RUN, WAIT_RD, WAIT_WR
  } state_t;

  state_t        state_q, state_d;
  logic          wr_bank_q, wr_bank_d;
  logic [AW-1:0] wr_cnt_q, wr_cnt_d;
  logic [AW-1:0] rd_cnt_q, rd_cnt_d;
  logic          swap_q, swap_d;
  logic          rd_valid_q, rd_valid_d;
  logic          rd_bank_q, rd_bank_d;

  logic wr_fire, rd_fire;
  logic wr_last, rd_last;
  logic do_swap;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= FILL0;
      wr_bank_q  <= 1'b0;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      swap_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_bank_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_bank_q  <= wr_bank_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      swap_q     <= swap_d;
      rd_valid_q <= rd_valid_d;
      rd_bank_q  <= rd_bank_d;
    end
  end

  // Handshake qualifiers are gated by reset so nothing strobes mid-reset.
  always_comb begin
    wr_ready = resetn && (state_q != WAIT_RD);
    rd_avail = resetn && ((state_q == RUN) ||
                          (state_q == WAIT_RD) ||
                          (REPEAT && state_q == WAIT_WR));
    wr_fire  = wr_valid && wr_ready;
    rd_fire  = rd_en && rd_avail;
    wr_last  = wr_fire && (&wr_cnt_q);
    rd_last  = rd_fire && (&rd_cnt_q);
  end

  always_comb begin
    state_d = state_q;
    do_swap = 1'b0;
    unique case (state_q)
      FILL0: begin
        if (wr_last) begin
          do_swap = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (wr_last && rd_last) do_swap = 1'b1;
        else if (wr_last)       state_d = WAIT_RD;
        else if (rd_last)       state_d = WAIT_WR;
      end
      WAIT_RD: begin
        if (rd_last) begin
          do_swap = 1'b1;
          state_d = RUN;
        end
      end
      WAIT_WR: begin
        if (wr_last) begin
          do_swap = 1'b1;
          state_d = RUN;
        end
      end
      default: state_d = FILL0;
    endcase
  end

  always_comb begin
    wr_cnt_d   = wr_fire ? wr_cnt_q + ONE : wr_cnt_q;
    rd_cnt_d   = rd_fire ? rd_cnt_q + ONE : rd_cnt_q;
    wr_bank_d  = wr_bank_q;
    swap_d     = do_swap;
    rd_valid_d = rd_fire;
    rd_bank_d  = rd_fire ? ~wr_bank_q : rd_bank_q;
    if (do_swap) begin
      wr_cnt_d  = '0;
      rd_cnt_d  = '0;
      wr_bank_d = ~wr_bank_q;
    end
  end

  always_comb begin
    ram1_write_en      = wr_fire && !wr_bank_q;
    ram2_write_en      = wr_fire &&  wr_bank_q;
    ram1_write_address = !wr_bank_q ? wr_cnt_q : '0;
    ram2_write_address =  wr_bank_q ? wr_cnt_q : '0;
    ram1_write_data    = ram1_write_en ? wr_data : '0;
    ram2_write_data    = ram2_write_en ? wr_data : '0;
    ram1_read_en       = rd_fire &&  wr_bank_q;
    ram2_read_en       = rd_fire && !wr_bank_q;
    ram1_read_address  =  wr_bank_q ? rd_cnt_q : '0;
    ram2_read_address  = !wr_bank_q ? rd_cnt_q : '0;
    rd_valid           = rd_valid_q;
    rd_data            = '0;
    if (rd_valid_q)
      rd_data = rd_bank_q ? ram2_read_data : ram1_read_data;
    wr_bank            = wr_bank_q;
    swap               = swap_q;
  end

endmodule

// File: tb/tb_bank_swap_scheduler.sv
// Scoreboard bench for bank_swap_scheduler with a frame-level reference
// model and behavioural 1-cycle-latency RAMs.
module tb_bank_swap_scheduler;

`ifdef BANK_SWAP_REPEAT_EN
  localparam bit REPEAT = 1'b1;
`else
  localparam bit REPEAT = 1'b0;
`endif
  localparam int DW = 8;
  localparam int AW = 5;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          resetn;
  logic          wr_valid;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic          rd_en;
  logic          rd_avail;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          ram1_write_en, ram2_write_en;
  logic [AW-1:0] ram1_write_address, ram2_write_address;
  logic [AW-1:0] ram1_read_address, ram2_read_address;
  logic [DW-1:0] ram1_write_data, ram2_write_data;
  logic          ram1_read_en, ram2_read_en;
  logic [DW-1:0] ram1_read_data, ram2_read_data;
  logic          wr_bank;
  logic          swap;

  bank_swap_scheduler #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .resetn(resetn),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_en(rd_en), .rd_avail(rd_avail),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .ram1_write_en(ram1_write_en), .ram2_write_en(ram2_write_en),
    .ram1_write_address(ram1_write_address),
    .ram2_write_address(ram2_write_address),
    .ram1_read_address(ram1_read_address),
    .ram2_read_address(ram2_read_address),
    .ram1_write_data(ram1_write_data),
    .ram2_write_data(ram2_write_data),
    .ram1_read_en(ram1_read_en), .ram2_read_en(ram2_read_en),
    .ram1_read_data(ram1_read_data), .ram2_read_data(ram2_read_data),
    .wr_bank(wr_bank), .swap(swap)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem1 [DEPTH];
  logic [DW-1:0] mem2 [DEPTH];
  logic [DW-1:0] r1 = '0;
  logic [DW-1:0] r2 = '0;
  assign ram1_read_data = r1;
  assign ram2_read_data = r2;

  always @(posedge clk) begin
    if (ram1_write_en) mem1[ram1_write_address] <= ram1_write_data;
    if (ram2_write_en) mem2[ram2_write_address] <= ram2_write_data;
    if (ram1_read_en)  r1 <= mem1[ram1_read_address];
    if (ram2_read_en)  r2 <= mem2[ram2_read_address];
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Frame-level model: a filling frame, a readable frame, read position.
  logic [DW-1:0] fill [$];
  logic [DW-1:0] rd_frame [DEPTH];
  logic [DW-1:0] sb [$];
  int rd_pos = 0;
  bit have_rd = 0;
  bit drained = 0;
  bit bank = 0;
  bit exp_swap = 0;
  bit prev_rf = 0;

  always @(negedge clk) begin
    if (rd_valid === 1'b1) begin
      if (sb.size() == 0) chk("rd_unexpected", 1, 0);
      else chk("rd_data", rd_data, sb.pop_front());
    end
  end

  task automatic step(input bit wv, input logic [DW-1:0] wd,
                      input bit re, input bit rn);
    bit wf, rf, ewr, erd;
    @(negedge clk);
    resetn = rn; wr_valid = wv; wr_data = wd; rd_en = re;
    #1;
    if (!rn) begin
      chk("rst_wr_ready", wr_ready, 0);
      chk("rst_rd_avail", rd_avail, 0);
      chk("rst_strobes", {ram1_write_en, ram2_write_en,
                          ram1_read_en, ram2_read_en}, 0);
      @(posedge clk); #1;
      chk("rst_outs", {rd_valid, swap, wr_bank}, 0);
      chk("rst_rd_data", rd_data, 0);
      chk("rst_addr", {ram1_write_address, ram2_write_address,
                       ram1_read_address, ram2_read_address}, 0);
      fill.delete(); sb.delete();
      rd_pos = 0; have_rd = 0; drained = 0; bank = 0;
      exp_swap = 0; prev_rf = 0;
      return;
    end
    chk("swap", swap, exp_swap);
    chk("wr_bank", wr_bank, bank);
    chk("rd_valid_timing", rd_valid, prev_rf);
    ewr = fill.size() < DEPTH;
    erd = have_rd && (!drained || REPEAT);
    chk("wr_ready", wr_ready, ewr);
    chk("rd_avail", rd_avail, erd);
    wf = wv && ewr;
    rf = re && erd;
    chk("w_en", {ram1_write_en, ram2_write_en}, {wf && !bank, wf && bank});
    chk("r_en", {ram1_read_en, ram2_read_en}, {rf && bank, rf && !bank});
    if (wf) begin
      chk("w_addr", bank ? ram2_write_address : ram1_write_address,
          fill.size());
      chk("w_data", bank ? ram2_write_data : ram1_write_data, wd);
      fill.push_back(wd);
    end
    if (rf) begin
      chk("r_addr", bank ? ram1_read_address : ram2_read_address, rd_pos);
      sb.push_back(rd_frame[rd_pos]);
      rd_pos++;
      if (rd_pos == DEPTH) begin
        rd_pos = 0;
        drained = 1;
      end
    end
    exp_swap = 0;
    if (fill.size() == DEPTH && (!have_rd || drained)) begin
      for (int i = 0; i < DEPTH; i++) rd_frame[i] = fill[i];
      fill.delete();
      rd_pos = 0; drained = 0; have_rd = 1;
      bank = ~bank; exp_swap = 1;
    end
    prev_rf = rf;
  endtask

  initial begin
    resetn = 0; wr_valid = 0; wr_data = '0; rd_en = 0;
    repeat (3) step(0, 0, 0, 0);
    // First fill with rd_en held: reads must be ignored.
    for (int i = 0; i < DEPTH; i++) step(1, DW'(i), 1, 1);
    step(0, 0, 0, 1);
    for (int i = 0; i < DEPTH; i++) step(0, 0, 1, 1);
    // Continuous streaming: swaps on coincident last write/read.
    for (int i = 0; i < 3 * DEPTH; i++) step(1, DW'($urandom), 1, 1);
    // Writer stalls at 10 words while reader drains.
    for (int i = 0; i < DEPTH; i++) step(i < 10, DW'($urandom), 1, 1);
    repeat (8) step(0, 0, 1, 1);
    for (int i = 0; i < 22; i++) step(1, DW'($urandom), 1, 1);
    // Writer fills while reader idles, then pushes into a full bank.
    for (int i = 0; i < DEPTH; i++) step(1, DW'($urandom), 0, 1);
    repeat (5) step(1, DW'($urandom), 0, 1);
    for (int i = 0; i < DEPTH; i++) step(1, DW'($urandom), 1, 1);
    // Reset mid-fill discards the partial bank.
    for (int i = 0; i < 17; i++) step(1, DW'($urandom), 0, 1);
    step(0, 0, 0, 0);
    step(1, 8'hA5, 0, 1);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 3) != 0, DW'($urandom),
           $urandom_range(0, 3) != 0, $urandom_range(0, 299) != 0);
    repeat (4) step(0, 0, 0, 1);
    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
